md_sched: RTL
=============

# md_sched

Multiply/divide sequencer for the execute stage of the pipelined MIPS core. Takes the opcode/funct fields of the E-stage instruction and its two operand values, issues mult/multu/div/divu as fixed-latency operations, owns the HI/LO registers, serves mfhi/mflo/mthi/mtlo, and raises a stall request toward decode while an operation is in flight and the D-stage instruction touches HI/LO.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd when enabled); legal 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal 1..15
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- e_valid  in  1  E-stage instruction valid (low on bubble/flush)
- e_opcode  in  6  E-stage instr[31:26]
- e_funct  in  6  E-stage instr[5:0]
- e_rs_val  in  32  forwarded rs operand
- e_rt_val  in  32  forwarded rt operand
- d_opcode  in  6  D-stage instr[31:26]
- d_funct  in  6  D-stage instr[5:0]
- start  out  1  combinational, high in issue cycle
- busy  out  1  registered, operation in flight
- stall_md  out  1  combinational stall request to D stage
- hi  out  32  HI register
- lo  out  32  LO register
- md_out  out  32  combinational mfhi/mflo read data

## Operation
- Decoding (SPECIAL = opcode 6'h00): mult 6'h18, multu 6'h19, div 6'h1A, divu 6'h1B, mfhi 6'h10, mthi 6'h11, mflo 6'h12, mtlo 6'h13. "MD-class" = any of these eight.
- States: IDLE (busy=0), RUN (busy=1). 4-bit down-counter cnt.
- IDLE, e_valid and mult-type: start=1; pending {HI,LO} computed from operands and latched; cnt<=MULT_CYCLES or DIV_CYCLES; go RUN.
- mult: signed 32x32->64, HI=upper, LO=lower. multu: unsigned. div: LO=signed quotient (truncate toward zero), HI=remainder (sign of dividend). divu: unsigned.
- Divide by zero: op runs full DIV_CYCLES, busy behaves normally, HI/LO left unchanged at completion.
- div 32'h80000000 / -1: LO=32'h80000000, HI=0.
- RUN: cnt decrements each edge; on the edge where cnt==1, HI/LO<=pending, go IDLE.
- mthi/mtlo in IDLE with e_valid: HI or LO <= e_rs_val at the edge. No busy.
- md_out = hi when e_funct==mfhi, else lo; meaningful only for mfhi/mflo.
- Any MD-class E-stage instruction arriving during RUN is ignored (no start, no HI/LO write); stall_md guarantees this does not occur in a correct pipeline.
- stall_md = (start | busy) & D-stage instruction is MD-class.
- Non-SPECIAL opcodes and other functs: no effect.

## Timing
- Reset: hi=0, lo=0, busy=0, cnt=0, pending=0, state IDLE; start/stall_md/md_out follow their combinational definitions from reset state.
- Issue in cycle T: start=1 in T; busy=1 in cycles T+1..T+N (N = configured latency); HI/LO new value visible in T+N+1 with busy=0.
- Back-to-back: a new mult-type may issue in T+N+1 (first cycle busy=0).
- mthi/mtlo in cycle T: value visible on hi/lo in T+1; mfhi in T+1 reads it.
- Reset asserted mid-RUN: in-flight result discarded, all state to reset values at that edge.
- e_valid=0: nothing issues or writes regardless of fields.

## Configuration
- MD_SCHED_MADD_EN defined: SPECIAL2 (opcode 6'h1C) funct 6'h00 = madd, funct 6'h01 = maddu; treated as mult-type with MULT_CYCLES latency; pending {HI,LO} = {HI,LO} + rs*rt (signed for madd, unsigned for maddu, 64-bit wrap), {HI,LO} sampled at issue; both counted as MD-class for stall_md.
- Undefined: opcode 6'h1C ignored entirely, not MD-class.

## Test plan
- Reset, then mult rs=32'hFFFFFFFE (-2), rt=3 -> start=1 at T, busy T+1..T+5, at T+6 hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
- multu same operands -> hi=32'h00000002, lo=32'hFFFFFFFA; divu 7/2 -> after 10 busy cycles lo=3, hi=1; div -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- div by 0 after mthi 32'h1234 / mtlo 32'h5678 -> busy 10 cycles, hi=32'h1234, lo=32'h5678 preserved.
- mult issued with D-stage mflo -> stall_md=1 in T..T+5, 0 in T+6; D-stage addu (SPECIAL funct 6'h21) -> stall_md=0 throughout.
- Reset pulsed at T+3 of a div -> busy=0, hi=lo=0 at T+4, no late HI/LO write.
- MD_SCHED_MADD_EN: hi=0, lo=32'hFFFFFFFF, madd rs=1, rt=1 -> after 5 cycles hi=1, lo=0; without macro same instruction -> start=0, hi/lo unchanged.

Source files
------------

// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched -- multiply/divide sequencer for the MIPS execute stage.
//
// Issues mult/multu/div/divu as fixed-latency operations, owns HI/LO, serves
// mfhi/mflo/mthi/mtlo and asks decode to stall while an operation is in
// flight and the D-stage instruction touches HI/LO.
//
// The result is computed in the issue cycle and parked in a pending register;
// the busy window only models the latency of an iterative unit so that
// software-visible timing matches the real core.
//
// Optional feature: define MD_SCHED_MADD_EN to decode SPECIAL2 madd/maddu
// (opcode 6'h1C, funct 6'h00/6'h01) as accumulate-multiplies with
// MULT_CYCLES latency. Without it opcode 6'h1C is ignored entirely.
//
// Parameters
//   MULT_CYCLES  busy cycles for mult/multu/madd/maddu (1..15)
//   DIV_CYCLES   busy cycles for div/divu (1..15)
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   e_valid    E-stage instruction valid
//   e_opcode   E-stage instr[31:26]
//   e_funct    E-stage instr[5:0]
//   e_rs_val   forwarded rs operand
//   e_rt_val   forwarded rt operand
//   d_opcode   D-stage instr[31:26]
//   d_funct    D-stage instr[5:0]
//   start      combinational, high in the issue cycle
//   busy       registered, operation in flight
//   stall_md   combinational stall request toward decode
//   hi, lo     HI/LO registers
//   md_out     combinational mfhi/mflo read data
// ---------------------------------------------------------------------------
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [5:0]  e_opcode,
  input  logic [5:0]  e_funct,
  input  logic [31:0] e_rs_val,
  input  logic [31:0] e_rt_val,
  input  logic [5:0]  d_opcode,
  input  logic [5:0]  d_funct,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] FN_MFHI     = 6'h10;
  localparam logic [5:0] FN_MTHI     = 6'h11;
  localparam logic [5:0] FN_MFLO     = 6'h12;
  localparam logic [5:0] FN_MTLO     = 6'h13;
  localparam logic [5:0] FN_MULT     = 6'h18;
  localparam logic [5:0] FN_MULTU    = 6'h19;
  localparam logic [5:0] FN_DIV      = 6'h1A;
  localparam logic [5:0] FN_DIVU     = 6'h1B;
  localparam logic [5:0] FN_MADD     = 6'h00;
  localparam logic [5:0] FN_MADDU    = 6'h01;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // True for any instruction that reads or writes HI/LO.
  function automatic logic is_md_class(input logic [5:0] op, input logic [5:0] fn);
    logic r;
    r = 1'b0;
    if (op == OP_SPECIAL) begin
      r = (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU) ||
          (fn == FN_MFHI) || (fn == FN_MTHI)  || (fn == FN_MFLO) || (fn == FN_MTLO);
    end
`ifdef MD_SCHED_MADD_EN
    if (op == OP_SPECIAL2) begin
      r = (fn == FN_MADD) || (fn == FN_MADDU);
    end
`endif
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic [63:0] pend_q,  pend_d;

  // -------------------------------------------------------------------------
  // E-stage decode
  // -------------------------------------------------------------------------
  logic e_special;
  logic e_mult, e_multu, e_div, e_divu, e_mthi, e_mtlo;
  logic e_madd, e_maddu;
  logic e_div_type, e_mult_type;

  assign e_special = (e_opcode == OP_SPECIAL);
  assign e_mult    = e_special && (e_funct == FN_MULT);
  assign e_multu   = e_special && (e_funct == FN_MULTU);
  assign e_div     = e_special && (e_funct == FN_DIV);
  assign e_divu    = e_special && (e_funct == FN_DIVU);
  assign e_mthi    = e_special && (e_funct == FN_MTHI);
  assign e_mtlo    = e_special && (e_funct == FN_MTLO);

`ifdef MD_SCHED_MADD_EN
  assign e_madd    = (e_opcode == OP_SPECIAL2) && (e_funct == FN_MADD);
  assign e_maddu   = (e_opcode == OP_SPECIAL2) && (e_funct == FN_MADDU);
`else
  assign e_madd    = 1'b0;
  assign e_maddu   = 1'b0;
`endif

  assign e_div_type  = e_div || e_divu;
  assign e_mult_type = e_mult || e_multu || e_madd || e_maddu || e_div_type;

  // -------------------------------------------------------------------------
  // Datapath: full result computed in the issue cycle
  // -------------------------------------------------------------------------
  logic [63:0] rs_sx, rt_sx;
  logic [63:0] prod_s, prod_u;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign rs_sx  = {{32{e_rs_val[31]}}, e_rs_val};
  assign rt_sx  = {{32{e_rt_val[31]}}, e_rt_val};
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = {32'd0, e_rs_val} * {32'd0, e_rt_val};

  // One unsigned divider serves both div and divu; signed division works on
  // magnitudes and fixes the signs afterwards. The magnitude of 32'h80000000
  // is itself as an unsigned value, which yields the required
  // 32'h80000000 / -1 = 32'h80000000, remainder 0 without a special case.
  logic        rs_neg, rt_neg;
  logic [31:0] dvd, dvs, q_u, r_u, quo, rem;

  assign rs_neg = e_div && e_rs_val[31];
  assign rt_neg = e_div && e_rt_val[31];
  assign dvd    = rs_neg ? (~e_rs_val + 32'd1) : e_rs_val;
  assign dvs    = rt_neg ? (~e_rt_val + 32'd1) : e_rt_val;
  assign q_u    = (dvs == 32'd0) ? 32'd0 : (dvd / dvs);
  assign r_u    = (dvs == 32'd0) ? 32'd0 : (dvd % dvs);
  assign quo    = (rs_neg ^ rt_neg) ? (~q_u + 32'd1) : q_u;
  assign rem    = rs_neg ? (~r_u + 32'd1) : r_u;

  logic [63:0] issue_result;

  always_comb begin
    issue_result = {hi_q, lo_q};
    if (e_mult) begin
      issue_result = prod_s;
    end else if (e_multu) begin
      issue_result = prod_u;
    end else if (e_div_type) begin
      // Divide by zero: write back the current HI/LO so completion is a no-op.
      // HI/LO cannot change during RUN, so this equals "left unchanged".
      if (e_rt_val != 32'd0) begin
        issue_result = {rem, quo};
      end
    end else if (e_madd) begin
      issue_result = {hi_q, lo_q} + prod_s;
    end else if (e_maddu) begin
      issue_result = {hi_q, lo_q} + prod_u;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (e_valid && e_mult_type) begin
          pend_d  = issue_result;
          cnt_d   = e_div_type ? DIV_CNT : MULT_CNT;
          state_d = S_RUN;
        end else if (e_valid && e_mthi) begin
          hi_d = e_rs_val;
        end else if (e_valid && e_mtlo) begin
          lo_d = e_rs_val;
        end
      end
      S_RUN: begin
        // MD-class E-stage instructions are deliberately ignored here.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign start    = (state_q == S_IDLE) && e_valid && e_mult_type;
  assign busy     = (state_q == S_RUN);
  assign stall_md = (start || busy) && is_md_class(d_opcode, d_funct);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_out   = (e_funct == FN_MFHI) ? hi_q : lo_q;

endmodule
